// File: rtl/dcache_mshr_ctrl.sv
// ============================================================================
//  Module   : dcache_mshr_ctrl
//  Brief    : Direct-mapped, write-through, no-write-allocate data cache with
//             a small MSHR file for load misses and a single memory port
//             shared between retiring stores and miss requests.
//  Options  : DCACHE_LD_MERGE_EN - when defined, a load miss to a block that
//             already has an outstanding MSHR entry is acknowledged without
//             allocating a new entry.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_mshr_ctrl #(
    parameter int MSHR_NUM = 4,
    parameter int LINE_NUM = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsq2Dcache_ld_en_i,
    input  logic [63:0] lsq2Dcache_ld_addr_i,
    input  logic        lsq2Dcache_st_en_i,
    input  logic [63:0] lsq2Dcache_st_addr_i,
    input  logic [63:0] lsq2Dcache_st_data_i,
    output logic        Dcache_hit_o,
    output logic [63:0] Dcache_data_o,
    output logic        Dcache_mshr_ld_ack_o,
    output logic        Dcache_mshr_st_ack_o,
    output logic        Dcache_mshr_vld_o,
    output logic [63:0] Dcache_mshr_addr_o,
    output logic        Dcache_mshr_stall_o,
    output logic [1:0]  proc2mem_command_o,
    output logic [63:0] proc2mem_addr_o,
    output logic [63:0] proc2mem_data_o,
    input  logic [3:0]  mem2proc_response_i,
    input  logic [63:0] mem2proc_data_i,
    input  logic [3:0]  mem2proc_tag_i
);

    localparam int IDX_W = $clog2(LINE_NUM);
    localparam int TAG_W = 61 - IDX_W;
    localparam int MI_W  = (MSHR_NUM > 1) ? $clog2(MSHR_NUM) : 1;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

`ifdef DCACHE_LD_MERGE_EN
    localparam logic LD_MERGE = 1'b1;
`else
    localparam logic LD_MERGE = 1'b0;
`endif

    typedef enum logic [1:0] {
        MSHR_EMPTY     = 2'd0,
        MSHR_WAIT_SEND = 2'd1,
        MSHR_WAIT_DATA = 2'd2
    } mshr_state_e;

    // MSHR entries hold the block number (address bits 63:3) and memory tag
    mshr_state_e      ent_state_q [MSHR_NUM];
    mshr_state_e      ent_state_d [MSHR_NUM];
    logic [60:0]      ent_blk_q   [MSHR_NUM];
    logic [60:0]      ent_blk_d   [MSHR_NUM];
    logic [3:0]       ent_tag_q   [MSHR_NUM];
    logic [3:0]       ent_tag_d   [MSHR_NUM];

    logic             line_valid_q [LINE_NUM];
    logic             line_valid_d [LINE_NUM];
    logic [TAG_W-1:0] line_tag_q   [LINE_NUM];
    logic [TAG_W-1:0] line_tag_d   [LINE_NUM];
    logic [63:0]      line_data_q  [LINE_NUM];
    logic [63:0]      line_data_d  [LINE_NUM];

    logic [60:0]      ld_blk;
    logic [60:0]      st_blk;
    logic [IDX_W-1:0] ld_idx;
    logic [IDX_W-1:0] st_idx;
    logic [TAG_W-1:0] ld_tag;
    logic [TAG_W-1:0] st_tag;
    logic             unused_low_bits;

    assign ld_blk = lsq2Dcache_ld_addr_i[63:3];
    assign st_blk = lsq2Dcache_st_addr_i[63:3];
    assign ld_idx = ld_blk[IDX_W-1:0];
    assign st_idx = st_blk[IDX_W-1:0];
    assign ld_tag = ld_blk[60:IDX_W];
    assign st_tag = st_blk[60:IDX_W];
    assign unused_low_bits = ^{lsq2Dcache_ld_addr_i[2:0], lsq2Dcache_st_addr_i[2:0]};

    logic            fill_hit;
    logic [MI_W-1:0] fill_sel;
    logic            free_found;
    logic [MI_W-1:0] free_sel;
    logic            send_found;
    logic [MI_W-1:0] send_sel;
    logic            ld_pending;
    logic            st_conflict;
    logic            all_busy;

    // Scan the MSHR file; descending order makes the lowest index win
    always_comb begin
        fill_hit    = 1'b0;
        fill_sel    = '0;
        free_found  = 1'b0;
        free_sel    = '0;
        send_found  = 1'b0;
        send_sel    = '0;
        ld_pending  = 1'b0;
        st_conflict = 1'b0;
        all_busy    = 1'b1;
        for (int i = MSHR_NUM - 1; i >= 0; i--) begin
            if (ent_state_q[i] == MSHR_WAIT_DATA && mem2proc_tag_i != 4'd0 &&
                ent_tag_q[i] == mem2proc_tag_i) begin
                fill_hit = 1'b1;
                fill_sel = MI_W'(i);
            end
            if (ent_state_q[i] == MSHR_EMPTY) begin
                free_found = 1'b1;
                free_sel   = MI_W'(i);
                all_busy   = 1'b0;
            end else begin
                if (ent_blk_q[i] == ld_blk) ld_pending  = 1'b1;
                if (ent_blk_q[i] == st_blk) st_conflict = 1'b1;
            end
            if (ent_state_q[i] == MSHR_WAIT_SEND) begin
                send_found = 1'b1;
                send_sel   = MI_W'(i);
            end
        end
    end

    logic fill_vld;
    logic ld_hit;
    logic ld_miss;
    logic ld_alloc;
    logic st_issue;
    logic ld_send;
    logic st_ack;

    // Request decisions and all LSQ / memory-bus outputs for this cycle
    always_comb begin
        fill_vld = !rst && fill_hit;
        ld_hit   = !rst && !fill_hit && lsq2Dcache_ld_en_i &&
                   line_valid_q[ld_idx] && (line_tag_q[ld_idx] == ld_tag);
        ld_miss  = !rst && !fill_hit && lsq2Dcache_ld_en_i && !ld_hit;
        ld_alloc = ld_miss && !ld_pending && free_found;
        st_issue = !rst && lsq2Dcache_st_en_i && !st_conflict;
        ld_send  = !rst && !st_issue && send_found;
        st_ack   = st_issue && (mem2proc_response_i != 4'd0);

        Dcache_hit_o         = ld_hit;
        Dcache_mshr_ld_ack_o = ld_miss && (ld_pending ? LD_MERGE : free_found);
        Dcache_mshr_st_ack_o = st_ack;
        Dcache_mshr_vld_o    = fill_vld;
        Dcache_mshr_addr_o   = fill_vld ? {ent_blk_q[fill_sel], 3'b000} : 64'd0;
        Dcache_mshr_stall_o  = !rst && all_busy;
        Dcache_data_o        = fill_vld ? mem2proc_data_i :
                               ld_hit   ? line_data_q[ld_idx] : 64'd0;

        proc2mem_command_o = CMD_NONE;
        proc2mem_addr_o    = 64'd0;
        proc2mem_data_o    = 64'd0;
        if (st_issue) begin
            proc2mem_command_o = CMD_STORE;
            proc2mem_addr_o    = {st_blk, 3'b000};
            proc2mem_data_o    = lsq2Dcache_st_data_i;
        end else if (ld_send) begin
            proc2mem_command_o = CMD_LOAD;
            proc2mem_addr_o    = {ent_blk_q[send_sel], 3'b000};
        end
    end

    // Next MSHR and line state; a fill is applied after a store update so a
    // fill replacing the same line index always leaves the filled block
    always_comb begin
        ent_state_d  = ent_state_q;
        ent_blk_d    = ent_blk_q;
        ent_tag_d    = ent_tag_q;
        line_valid_d = line_valid_q;
        line_tag_d   = line_tag_q;
        line_data_d  = line_data_q;

        if (ld_send && mem2proc_response_i != 4'd0) begin
            ent_state_d[send_sel] = MSHR_WAIT_DATA;
            ent_tag_d[send_sel]   = mem2proc_response_i;
        end
        if (fill_vld) begin
            ent_state_d[fill_sel] = MSHR_EMPTY;
        end
        if (ld_alloc) begin
            ent_state_d[free_sel] = MSHR_WAIT_SEND;
            ent_blk_d[free_sel]   = ld_blk;
        end

        if (st_ack && line_valid_q[st_idx] && line_tag_q[st_idx] == st_tag) begin
            line_data_d[st_idx] = lsq2Dcache_st_data_i;
        end
        if (fill_vld) begin
            line_valid_d[ent_blk_q[fill_sel][IDX_W-1:0]] = 1'b1;
            line_tag_d[ent_blk_q[fill_sel][IDX_W-1:0]]   = ent_blk_q[fill_sel][60:IDX_W];
            line_data_d[ent_blk_q[fill_sel][IDX_W-1:0]]  = mem2proc_data_i;
        end
    end

    // Control state: entries and valid bits cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MSHR_NUM; i++) begin
                ent_state_q[i] <= MSHR_EMPTY;
                ent_blk_q[i]   <= '0;
                ent_tag_q[i]   <= '0;
            end
            for (int j = 0; j < LINE_NUM; j++) begin
                line_valid_q[j] <= 1'b0;
            end
        end else begin
            ent_state_q  <= ent_state_d;
            ent_blk_q    <= ent_blk_d;
            ent_tag_q    <= ent_tag_d;
            line_valid_q <= line_valid_d;
        end
    end

    // Line tag and data storage; contents are qualified by the valid bits
    always_ff @(posedge clk) begin
        line_tag_q  <= line_tag_d;
        line_data_q <= line_data_d;
    end

endmodule

`default_nettype wire

// File: tb/tb_dcache_mshr_ctrl.sv
// ============================================================================
//  Module   : tb_dcache_mshr_ctrl
//  Brief    : Self-checking bench for dcache_mshr_ctrl: directed scenarios
//             followed by random traffic, compared against a block-level
//             reference model of the cache and its outstanding misses.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_mshr_ctrl;

    localparam int N = 4;
    localparam int L = 32;
`ifdef DCACHE_LD_MERGE_EN
    localparam logic MERGE = 1'b1;
`else
    localparam logic MERGE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_en = 1'b0;
    logic [63:0] ld_addr = 64'd0;
    logic        st_en = 1'b0;
    logic [63:0] st_addr = 64'd0;
    logic [63:0] st_data = 64'd0;
    logic [3:0]  resp = 4'd0;
    logic [63:0] mdata = 64'd0;
    logic [3:0]  mtag = 4'd0;

    logic        hit, ld_ack, st_ack, vld, stall;
    logic [63:0] data, maddr, paddr, pdata;
    logic [1:0]  cmd;

    dcache_mshr_ctrl #(.MSHR_NUM(N), .LINE_NUM(L)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .lsq2Dcache_ld_en_i   (ld_en),
        .lsq2Dcache_ld_addr_i (ld_addr),
        .lsq2Dcache_st_en_i   (st_en),
        .lsq2Dcache_st_addr_i (st_addr),
        .lsq2Dcache_st_data_i (st_data),
        .Dcache_hit_o         (hit),
        .Dcache_data_o        (data),
        .Dcache_mshr_ld_ack_o (ld_ack),
        .Dcache_mshr_st_ack_o (st_ack),
        .Dcache_mshr_vld_o    (vld),
        .Dcache_mshr_addr_o   (maddr),
        .Dcache_mshr_stall_o  (stall),
        .proc2mem_command_o   (cmd),
        .proc2mem_addr_o      (paddr),
        .proc2mem_data_o      (pdata),
        .mem2proc_response_i  (resp),
        .mem2proc_data_i      (mdata),
        .mem2proc_tag_i       (mtag)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: outstanding misses as (busy, sent, block address, tag);
    // cache as per-index (valid, block address, data)
    bit          m_busy [N];
    bit          m_sent [N];
    logic [63:0] m_addr [N];
    logic [3:0]  m_tag  [N];
    bit          m_lv   [L];
    logic [63:0] m_lblk [L];
    logic [63:0] m_ldat [L];

    // Observed values of the most recent cycle, for directed checks
    logic        o_hit, o_ack, o_sack, o_vld, o_stall;
    logic [63:0] o_data, o_maddr, o_paddr;
    logic [1:0]  o_cmd;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    endtask

    function automatic int line_of(input logic [63:0] a);
        return int'((a >> 3) % L);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 0; m_sent[i] = 0; m_addr[i] = 0; m_tag[i] = 0;
        end
        for (int j = 0; j < L; j++) begin
            m_lv[j] = 0; m_lblk[j] = 0; m_ldat[j] = 0;
        end
    endtask

    // Evaluate one cycle: compare DUT outputs with the model, then advance it
    task automatic model_cycle();
        int f, nbusy, sendi, freei, li;
        logic [63:0] lblk, sblk;
        bit pend, sconf, e_hit, e_ack, e_sack;
        logic [63:0] e_data, e_maddr, e_paddr, e_pdata;
        logic [1:0] e_cmd;

        o_hit = hit; o_ack = ld_ack; o_sack = st_ack; o_vld = vld; o_stall = stall;
        o_data = data; o_maddr = maddr; o_paddr = paddr; o_cmd = cmd;

        if (rst) begin
            check("rst_hit", 64'(hit), 0);     check("rst_ld_ack", 64'(ld_ack), 0);
            check("rst_st_ack", 64'(st_ack), 0); check("rst_vld", 64'(vld), 0);
            check("rst_stall", 64'(stall), 0); check("rst_cmd", 64'(cmd), 0);
            check("rst_data", data, 0);        check("rst_maddr", maddr, 0);
            check("rst_paddr", paddr, 0);      check("rst_pdata", pdata, 0);
            model_reset();
            return;
        end

        lblk = ld_addr & ~64'd7;
        sblk = st_addr & ~64'd7;
        f = -1; nbusy = 0; sendi = -1; freei = -1; pend = 0; sconf = 0;
        for (int i = 0; i < N; i++) begin
            if (f < 0 && m_busy[i] && m_sent[i] && mtag != 0 && m_tag[i] == mtag) f = i;
            if (m_busy[i]) begin
                nbusy++;
                if (m_addr[i] == lblk) pend = 1;
                if (m_addr[i] == sblk) sconf = 1;
                if (sendi < 0 && !m_sent[i]) sendi = i;
            end else if (freei < 0) freei = i;
        end

        e_hit = 0; e_ack = 0; e_data = 0; e_maddr = 0;
        li = line_of(lblk);
        if (f >= 0) begin
            e_data = mdata; e_maddr = m_addr[f];
        end else if (ld_en) begin
            if (m_lv[li] && m_lblk[li] == lblk) begin
                e_hit = 1; e_data = m_ldat[li];
            end else if (pend) e_ack = MERGE;
            else if (nbusy < N) e_ack = 1;
        end

        e_cmd = 0; e_paddr = 0; e_pdata = 0;
        if (st_en && !sconf) begin
            e_cmd = 2; e_paddr = sblk; e_pdata = st_data;
        end else if (sendi >= 0) begin
            e_cmd = 1; e_paddr = m_addr[sendi];
        end
        e_sack = (e_cmd == 2) && resp != 0;

        check("hit", 64'(hit), 64'(e_hit));        check("data", data, e_data);
        check("ld_ack", 64'(ld_ack), 64'(e_ack));  check("st_ack", 64'(st_ack), 64'(e_sack));
        check("mshr_vld", 64'(vld), 64'(f >= 0));  check("mshr_addr", maddr, e_maddr);
        check("stall", 64'(stall), 64'(nbusy == N)); check("cmd", 64'(cmd), 64'(e_cmd));
        check("mem_addr", paddr, e_paddr);         check("mem_data", pdata, e_pdata);

        if (e_sack && m_lv[line_of(sblk)] && m_lblk[line_of(sblk)] == sblk)
            m_ldat[line_of(sblk)] = st_data;
        if (e_cmd == 1 && resp != 0) begin
            m_sent[sendi] = 1; m_tag[sendi] = resp;
        end
        if (f >= 0) begin
            m_lv[line_of(m_addr[f])]   = 1;
            m_lblk[line_of(m_addr[f])] = m_addr[f];
            m_ldat[line_of(m_addr[f])] = mdata;
            m_busy[f] = 0;
        end
        if (e_ack && !pend) begin
            m_busy[freei] = 1; m_sent[freei] = 0; m_addr[freei] = lblk;
        end
    endtask

    // Drive one cycle of inputs, check mid-cycle, then step to the next edge
    task automatic cyc(input logic l_en, input logic [63:0] l_a, input logic s_en,
                       input logic [63:0] s_a, input logic [63:0] s_d,
                       input logic [3:0] r, input logic [3:0] t, input logic [63:0] d);
        ld_en = l_en; ld_addr = l_a; st_en = s_en; st_addr = s_a; st_data = s_d;
        resp = r; mtag = t; mdata = d;
        #3;
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] pick_resp();
        logic [3:0] t;
        bit used;
        if ($urandom_range(0, 3) == 0) return 4'd0;
        for (int k = 0; k < 64; k++) begin
            t = 4'($urandom_range(1, 15));
            used = 0;
            for (int i = 0; i < N; i++)
                if (m_busy[i] && m_sent[i] && m_tag[i] == t) used = 1;
            if (!used) return t;
        end
        return 4'd0;
    endfunction

    function automatic logic [3:0] pick_tag();
        int r, i;
        r = $urandom_range(0, 9);
        i = $urandom_range(0, N - 1);
        if (r < 4 && m_busy[i] && m_sent[i]) return m_tag[i];
        if (r == 4) return 4'($urandom_range(1, 15));
        return 4'd0;
    endfunction

    initial begin
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Cold miss, fill, then hit
        cyc(1, 64'h100, 0, 0, 0, 0, 0, 0);
        check("cold_ack", 64'(o_ack), 1); check("cold_hit", 64'(o_hit), 0);
        cyc(0, 0, 0, 0, 0, 3, 0, 0);
        check("cold_cmd", 64'(o_cmd), 1); check("cold_paddr", o_paddr, 64'h100);
        cyc(0, 0, 0, 0, 0, 0, 3, 64'hAA);
        check("fill_vld", 64'(o_vld), 1); check("fill_addr", o_maddr, 64'h100);
        check("fill_data", o_data, 64'hAA);
        cyc(1, 64'h104, 0, 0, 0, 0, 0, 0);
        check("rehit", 64'(o_hit), 1); check("rehit_data", o_data, 64'hAA);

        // Store write-through, accepted then refused
        cyc(0, 0, 1, 64'h100, 64'h55, 2, 0, 0);
        check("st_cmd", 64'(o_cmd), 2); check("st_ack1", 64'(o_sack), 1);
        cyc(1, 64'h100, 0, 0, 0, 0, 0, 0);
        check("st_hit", o_data, 64'h55);
        cyc(0, 0, 1, 64'h100, 64'h77, 0, 0, 0);
        check("st_refused", 64'(o_sack), 0);
        cyc(1, 64'h100, 0, 0, 0, 0, 0, 0);
        check("st_unchanged", o_data, 64'h55);

        // Fill the MSHR file
        cyc(1, 64'h200, 0, 0, 0, 0, 0, 0);
        cyc(1, 64'h300, 0, 0, 0, 1, 0, 0);
        cyc(1, 64'h400, 0, 0, 0, 2, 0, 0);
        cyc(1, 64'h500, 0, 0, 0, 4, 0, 0);
        cyc(1, 64'h600, 0, 0, 0, 5, 0, 0);
        check("full_stall", 64'(o_stall), 1); check("full_noack", 64'(o_ack), 0);
        cyc(1, 64'h100, 0, 0, 0, 0, 0, 0);
        check("full_hit", 64'(o_hit), 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 64'h22);
        check("full_fill", o_maddr, 64'h200);
        cyc(1, 64'h600, 0, 0, 0, 0, 0, 0);
        check("unfull_stall", 64'(o_stall), 0); check("unfull_ack", 64'(o_ack), 1);
        cyc(0, 0, 0, 0, 0, 0, 2, 64'h33);
        cyc(0, 0, 0, 0, 0, 6, 4, 64'h44);
        cyc(0, 0, 0, 0, 0, 0, 5, 64'h55);
        cyc(0, 0, 0, 0, 0, 0, 6, 64'h66);

        // Store blocked by a pending miss to the same block
        cyc(1, 64'h800, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 64'h800, 64'h88, 7, 0, 0);
        check("conf_noack", 64'(o_sack), 0); check("conf_cmd", 64'(o_cmd), 1);
        cyc(0, 0, 1, 64'h800, 64'h88, 3, 7, 64'h80);
        check("conf_fill_noack", 64'(o_sack), 0);
        cyc(0, 0, 1, 64'h800, 64'h88, 3, 0, 0);
        check("conf_ack", 64'(o_sack), 1);

        // Second miss to a pending block
        cyc(1, 64'h900, 0, 0, 0, 0, 0, 0);
        cyc(1, 64'h900, 0, 0, 0, 8, 0, 0);
        check("merge_ack", 64'(o_ack), 64'(MERGE)); check("merge_paddr", o_paddr, 64'h900);
        cyc(0, 0, 0, 0, 0, 9, 0, 0);
        check("merge_oneload", 64'(o_cmd), 0);
        cyc(0, 0, 0, 0, 0, 0, 8, 64'h99);

        // Reset with two misses waiting for data
        cyc(1, 64'hB00, 0, 0, 0, 0, 0, 0);
        cyc(1, 64'hC00, 0, 0, 0, 10, 0, 0);
        cyc(0, 0, 0, 0, 0, 11, 0, 0);
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 10, 64'h1234);
        check("post_rst_vld", 64'(o_vld), 0); check("post_rst_stall", 64'(o_stall), 0);
        cyc(1, 64'h800, 0, 0, 0, 0, 0, 0);
        check("post_rst_miss", 64'(o_hit), 0);

        // Random traffic over a small address pool with aliasing indices
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            cyc($urandom_range(0, 9) < 6, 64'($urandom_range(0, 63) * 8 + $urandom_range(0, 7)),
                $urandom_range(0, 9) < 4, 64'($urandom_range(0, 63) * 8 + $urandom_range(0, 7)),
                {$urandom, $urandom}, pick_resp(), pick_tag(), {$urandom, $urandom});
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dcache_mshr_ctrl.md
# dcache_mshr_ctrl

Data-cache controller that answers the load/store queue's Dcache request interface and drives the main-memory bus. It is a direct-mapped, write-through, no-write-allocate cache.
- Load hits return data in the same cycle.
- Load misses are parked in a small miss-status holding register (MSHR) file, sent to memory, and broadcast back to the LSQ when the fill arrives.
- Retired stores are written through to memory, one per cycle at most.

## Interface
Parameters:
- MSHR_NUM, 4: number of MSHR entries (power of 2, ≤8).
- LINE_NUM, 32: cache lines; 8-byte blocks; index = addr[3+log2(LINE_NUM)-1:3], tag = remaining upper bits.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  clock.
  - rst  in  1  synchronous active-high reset.
- Load request from LSQ:
  - lsq2Dcache_ld_en_i  in  1  load request.
  - lsq2Dcache_ld_addr_i  in  64  load address.
- Store request from LSQ:
  - lsq2Dcache_st_en_i  in  1  store request.
  - lsq2Dcache_st_addr_i  in  64  store address.
  - lsq2Dcache_st_data_i  in  64  store data.
- Responses to LSQ:
  - Dcache_hit_o  out  1  load hit this cycle.
  - Dcache_data_o  out  64  hit data, or fill data when Dcache_mshr_vld_o.
  - Dcache_mshr_ld_ack_o  out  1  load miss accepted into MSHR.
  - Dcache_mshr_st_ack_o  out  1  store accepted by memory.
  - Dcache_mshr_vld_o  out  1  fill broadcast this cycle.
  - Dcache_mshr_addr_o  out  64  block-aligned fill address.
  - Dcache_mshr_stall_o  out  1  all MSHR entries busy.
- Memory bus:
  - proc2mem_command_o  out  2  0=NONE, 1=LOAD, 2=STORE.
  - proc2mem_addr_o  out  64  block-aligned address.
  - proc2mem_data_o  out  64  store data.
  - mem2proc_response_i  in  4  transaction tag; 0 = request refused.
  - mem2proc_data_i  in  64  returned block.
  - mem2proc_tag_i  in  4  tag of returned data; 0 = none.

## Operation
- Fill detection: a fill is present in a cycle when mem2proc_tag_i≠0 and it equals the memory tag of an entry in WAIT_DATA.
- Fill cycle:
  - Dcache_mshr_vld_o=1, Dcache_mshr_addr_o=entry address, Dcache_data_o=mem2proc_data_i.
  - Line written and made valid; entry returns to EMPTY.
  - Load requests are ignored: hit=0, ld_ack=0.
- Load, no fill this cycle:
  - Tag match on a valid line: Dcache_hit_o=1 with the line data.
  - Otherwise a miss, allocated to the lowest-index EMPTY entry (→WAIT_SEND), with Dcache_mshr_ld_ack_o=1.
  - A miss is not acknowledged when no entry is free.
- MSHR entry FSM:
  - EMPTY→WAIT_SEND on allocate.
  - WAIT_SEND→WAIT_DATA when its LOAD command is accepted (response≠0); the tag is recorded.
  - WAIT_DATA→EMPTY on matching fill.
- Memory arbitration, one command per cycle:
  - Store eligibility: an eligible store has priority. A store is eligible when st_en=1 and no non-EMPTY entry holds the same block address.
  - Load send: otherwise the lowest-index WAIT_SEND entry sends LOAD.
  - Idle: otherwise command NONE.
- Store:
  - Dcache_mshr_st_ack_o = store issued && response≠0.
  - On ack, a valid line with a tag match is updated with the store data.
  - A refused or ineligible store gets no ack; the LSQ holds it.
- Dcache_mshr_stall_o=1 when all entries are non-EMPTY.

## Timing
- Hit, ld_ack, st_ack, mshr_vld and stall are combinational in the current cycle; state updates on the next clk edge.
- Miss latency:
  - The earliest LOAD command is the cycle after ld_ack.
  - The fill broadcast is the cycle mem2proc_tag_i matches.
- Reset values:
  - All outputs 0; proc2mem_command_o=NONE.
  - All line valid bits clear; all entries EMPTY.
  - Reset mid-miss discards outstanding entries. A later fill tag matches nothing and is ignored.
- Simultaneous events:
  - An entry freed by a fill is reusable from the next cycle.
  - Send and fill of different entries may occur in the same cycle.
  - A store to a line being filled in the same cycle is blocked by the address conflict rule.
- Full MSHR: stall=1 and misses get ld_ack=0; hits are still served.
- Duplicate-tag fill (not possible with a correct memory): the lowest-index match wins.

## Configuration
- DCACHE_LD_MERGE_EN defined: a miss whose block matches a non-EMPTY entry is acked (ld_ack=1) without allocating; the LSQ's address broadcast match covers it. This is allowed even when the MSHR is full.
- Not defined: such a miss gets ld_ack=0 until the matching entry frees.

## Test plan
- Cold miss: ld 0x100 → ld_ack=1, hit=0.
  - Next cycle: LOAD 0x100 with response=3.
  - mem tag=3, data=0xAA → mshr_vld=1, addr=0x100, data=0xAA.
  - ld 0x100 again → hit=1, data=0xAA.
- Store write-through:
  - Line 0x100 valid; st 0x100/0x55 with response=2 → STORE command, st_ack=1.
  - ld 0x100 → hit, 0x55.
  - With response=0 → st_ack=0 and the line is unchanged.
- MSHR full: 4 misses to 0x200, 0x300, 0x400, 0x500 → stall=1.
  - 5th miss 0x600 → ld_ack=0.
  - Fill of 0x200 → stall=0 next cycle; 0x600 then acked.
- Store–miss conflict: miss 0x800 pending; st 0x800 → st_ack=0.
  - After the 0x800 fill, the store is acked.
- Merge: second miss 0x900 while 0x900 is pending.
  - ld_ack=1 with the macro defined, 0 without.
  - Exactly one LOAD 0x900 is issued.
- Reset with two WAIT_DATA entries → stall=0, all outputs 0; the subsequent fill tag is ignored (mshr_vld=0).
